// File: rtl/debug_mem_arb.sv
// debug_mem_arb: two-requester round-robin arbiter onto one shared debug memory port.
// Latency: PVALID rises one edge after a VALID is sampled; READY pulses one edge after PREADY (or timeout).
// Backpressure: requesters hold VALID until their READY pulse; the downstream stalls via PREADY, bounded by TIMEOUT.
//
// Ports:
//   CLK, RST_N                        clock, async active-low reset
//   A_VALID/A_WSTB/A_ADDR/A_WDATA     requester A (abstract command) request; WSTB==0 is a read
//   A_READY/A_RDATA/A_EXCEPT          requester A completion
//   B_*                               requester B (system bus), same shape as A
//   PVALID/PWSTB/PADDR/PWDATA         shared downstream request
//   PREADY/PRDATA/PEXCEPT             shared downstream response
//   BUSY                              transaction in flight (BUSY or DONE state)
//   GRANT                             last/current owner, 0=A 1=B
module debug_mem_arb #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST_N,

  input  logic        A_VALID,
  input  logic [3:0]  A_WSTB,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_WDATA,
  output logic        A_READY,
  output logic [31:0] A_RDATA,
  output logic        A_EXCEPT,

  input  logic        B_VALID,
  input  logic [3:0]  B_WSTB,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_WDATA,
  output logic        B_READY,
  output logic [31:0] B_RDATA,
  output logic        B_EXCEPT,

  output logic        PVALID,
  output logic [3:0]  PWSTB,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PEXCEPT,

  output logic        BUSY,
  output logic        GRANT
);

  // With TIMEOUT==0 the counter is never used; keep it one bit wide so it stays a legal vector.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          grant_q;
  logic [CW-1:0] cnt;
  logic [3:0]    pwstb_q;
  logic [31:0]   paddr_q;
  logic [31:0]   pwdata_q;
  logic [31:0]   a_rdata_q;
  logic          a_except_q;
  logic [31:0]   b_rdata_q;
  logic          b_except_q;

  logic          any_req;
  logic          pick_b;
  logic          timeout_hit;

  // Next-state and arbitration decode.
  always_comb begin
    state_nxt   = state;
    any_req     = A_VALID || B_VALID;
    // Both requesting: hand the port to whoever did not own it last.
    // Single requester: B_VALID alone selects B, A_VALID alone selects A.
    pick_b      = (A_VALID && B_VALID) ? ~grant_q : B_VALID;
    // PREADY takes priority over the abort in the same cycle.
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !PREADY;

    case (state)
      ST_IDLE: if (any_req)                state_nxt = ST_BUSY;
      ST_BUSY: if (PREADY || timeout_hit)  state_nxt = ST_DONE;
      ST_DONE:                             state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, completion capture and stall counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_q    <= 1'b1;  // so that A wins the first contention
      cnt        <= '0;
      pwstb_q    <= '0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      a_rdata_q  <= '0;
      a_except_q <= 1'b0;
      b_rdata_q  <= '0;
      b_except_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q  <= pick_b;
            pwstb_q  <= pick_b ? B_WSTB  : A_WSTB;
            paddr_q  <= pick_b ? B_ADDR  : A_ADDR;
            pwdata_q <= pick_b ? B_WDATA : A_WDATA;
            cnt      <= '0;
          end
        end

        ST_BUSY: begin
          if (PREADY) begin
            if (grant_q) begin
              b_rdata_q  <= PRDATA;
              b_except_q <= PEXCEPT;
            end else begin
              a_rdata_q  <= PRDATA;
              a_except_q <= PEXCEPT;
            end
          end else if (timeout_hit) begin
            // Aborted access: report an exception with zero data to the owner.
            if (grant_q) begin
              b_rdata_q  <= '0;
              b_except_q <= 1'b1;
            end else begin
              a_rdata_q  <= '0;
              a_except_q <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (cnt != CNT_LAST)) begin
            // Saturates by construction: reaching CNT_LAST leaves BUSY.
            cnt <= cnt + 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  // Status and handshake outputs are pure state decodes, so reset drops them asynchronously.
  assign PVALID   = (state == ST_BUSY);
  assign PWSTB    = pwstb_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;

  assign A_READY  = (state == ST_DONE) && !grant_q;
  assign B_READY  = (state == ST_DONE) &&  grant_q;
  assign A_RDATA  = a_rdata_q;
  assign A_EXCEPT = a_except_q;
  assign B_RDATA  = b_rdata_q;
  assign B_EXCEPT = b_except_q;

  assign BUSY     = (state != ST_IDLE);
  assign GRANT    = grant_q;

endmodule

// File: tb/tb_debug_mem_arb.sv
// tb_debug_mem_arb: randomized two-requester traffic plus directed cases against debug_mem_arb.
// Main instance uses TIMEOUT=8; a second instance uses TIMEOUT=0 for the long-stall case.
// Responses predicted at grant time are queued and popped by a separate READY monitor.
module tb_debug_mem_arb;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  // Requester side, index 0 = A, 1 = B.
  logic        valid [2];
  logic [3:0]  wstb  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        a_ready, b_ready, a_exc, b_exc;
  logic [31:0] a_rdata, b_rdata;

  logic        pvalid;
  logic [3:0]  pwstb;
  logic [31:0] paddr, pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pexcept;
  logic        busy, grant;

  debug_mem_arb #(.TIMEOUT(TO)) dut (
    .CLK(clk), .RST_N(rst_n),
    .A_VALID(valid[0]), .A_WSTB(wstb[0]), .A_ADDR(addr[0]), .A_WDATA(wdata[0]),
    .A_READY(a_ready), .A_RDATA(a_rdata), .A_EXCEPT(a_exc),
    .B_VALID(valid[1]), .B_WSTB(wstb[1]), .B_ADDR(addr[1]), .B_WDATA(wdata[1]),
    .B_READY(b_ready), .B_RDATA(b_rdata), .B_EXCEPT(b_exc),
    .PVALID(pvalid), .PWSTB(pwstb), .PADDR(paddr), .PWDATA(pwdata),
    .PREADY(pready), .PRDATA(prdata), .PEXCEPT(pexcept),
    .BUSY(busy), .GRANT(grant)
  );

  // Second instance with the timeout disabled; only requester A is used.
  logic        z_valid, z_pready, z_pexcept;
  logic [31:0] z_addr, z_wdata, z_prdata;
  logic        z_a_ready, z_a_exc, z_b_ready, z_b_exc, z_pvalid, z_busy, z_grant;
  logic [31:0] z_a_rdata, z_b_rdata, z_paddr, z_pwdata;
  logic [3:0]  z_pwstb;

  debug_mem_arb #(.TIMEOUT(0)) dut0 (
    .CLK(clk), .RST_N(rst_n),
    .A_VALID(z_valid), .A_WSTB(4'h0), .A_ADDR(z_addr), .A_WDATA(z_wdata),
    .A_READY(z_a_ready), .A_RDATA(z_a_rdata), .A_EXCEPT(z_a_exc),
    .B_VALID(1'b0), .B_WSTB(4'h0), .B_ADDR(32'h0), .B_WDATA(32'h0),
    .B_READY(z_b_ready), .B_RDATA(z_b_rdata), .B_EXCEPT(z_b_exc),
    .PVALID(z_pvalid), .PWSTB(z_pwstb), .PADDR(z_paddr), .PWDATA(z_pwdata),
    .PREADY(z_pready), .PRDATA(z_prdata), .PEXCEPT(z_pexcept),
    .BUSY(z_busy), .GRANT(z_grant)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic ready_of(input int s);
    return (s != 0) ? b_ready : a_ready;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        exc;
  } resp_t;

  resp_t qa[$];
  resp_t qb[$];

  // Downstream responder knobs for directed cases.
  bit          fix_en;
  int          fix_lat;
  logic [31:0] fix_data;
  bit          fix_exc;

  // Reference model state.
  bit          prev_pv, prev_v0, prev_v1, model_last;
  int          bcnt, lat, exp_len, own;
  logic [3:0]  e_wstb;
  logic [31:0] e_addr, e_wdata, r_data;
  bit          r_exc;

  // Responder + model: at each new downstream transaction, predict the owner by
  // round-robin over the requests that were pending, choose a response latency,
  // and queue the completion that owner should see.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pv = 0; prev_v0 = 0; prev_v1 = 0; model_last = 1;
      bcnt = 0; lat = 0; exp_len = 0;
      qa.delete(); qb.delete();
      pready = 0;
    end else begin
      pready  = 0;
      prdata  = $urandom;
      pexcept = 1'($urandom_range(0, 1));
      if (pvalid && !prev_pv) begin
        if (!prev_v0 && !prev_v1) begin
          chk("grant_without_request", pvalid, 0);
          own = 0;
        end else if (prev_v0 && prev_v1) begin
          own = model_last ? 0 : 1;
        end else begin
          own = prev_v0 ? 0 : 1;
        end
        model_last = (own != 0);
        chk("grant_owner", grant, own);
        e_wstb = wstb[own]; e_addr = addr[own]; e_wdata = wdata[own];
        if (fix_en) begin
          lat = fix_lat; r_data = fix_data; r_exc = fix_exc;
        end else begin
          lat = $urandom_range(1, 11); r_data = $urandom; r_exc = ($urandom_range(0, 3) == 0);
        end
        if (lat <= TO) begin
          exp_len = lat;
          if (own == 0) qa.push_back('{r_data, r_exc}); else qb.push_back('{r_data, r_exc});
        end else begin
          exp_len = TO;
          if (own == 0) qa.push_back('{32'h0, 1'b1}); else qb.push_back('{32'h0, 1'b1});
        end
        bcnt = 0;
      end
      if (pvalid) begin
        bcnt++;
        chk("p_fields", {pwstb, paddr, pwdata}, {e_wstb, e_addr, e_wdata});
        if (bcnt == lat) begin
          pready = 1; prdata = r_data; pexcept = r_exc;
        end
      end else begin
        if (prev_pv) chk("pvalid_len", bcnt, exp_len);
        // Stray PREADY while no transaction is in flight must be ignored.
        pready = ($urandom_range(0, 2) == 0);
      end
      chk("busy_flag", busy, pvalid || prev_pv);
      prev_pv = pvalid; prev_v0 = valid[0]; prev_v1 = valid[1];
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    resp_t r;
    if (rst_n) begin
      chk("ready_exclusive", a_ready & b_ready, 0);
      if (a_ready) begin
        if (qa.size() == 0) chk("a_ready_unexpected", a_ready, 0);
        else begin
          r = qa.pop_front();
          chk("a_rdata", a_rdata, r.data);
          chk("a_except", a_exc, r.exc);
        end
      end
      if (b_ready) begin
        if (qb.size() == 0) chk("b_ready_unexpected", b_ready, 0);
        else begin
          r = qb.pop_front();
          chk("b_rdata", b_rdata, r.data);
          chk("b_except", b_exc, r.exc);
        end
      end
    end
  end

  task automatic do_req(input int s, input logic [3:0] st, input logic [31:0] ad,
                        input logic [31:0] wd, input bit violate);
    int k;
    @(posedge clk); #1;
    wstb[s] = st; addr[s] = ad; wdata[s] = wd; valid[s] = 1'b1;
    if (violate) begin
      // Once served, drop VALID and scramble fields; the transaction must still complete.
      k = 0;
      do begin @(negedge clk); k++; end while (!(pvalid && grant == s[0]) && k < 300);
      @(posedge clk); #1;
      valid[s] = 1'b0; addr[s] = $urandom; wdata[s] = $urandom; wstb[s] = 4'($urandom);
    end
    k = 0;
    do begin @(negedge clk); k++; end while (!ready_of(s) && k < 300);
    chk("ready_seen", ready_of(s), 1);
    @(posedge clk); #1;
    valid[s] = 1'b0;
  endtask

  task automatic rand_driver(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(s, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom, $urandom,
             ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, expected finish before 600000");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b1;
    valid[0] = 0; valid[1] = 0;
    wstb[0] = 0; wstb[1] = 0; addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    fix_en = 0; fix_lat = 1; fix_data = 0; fix_exc = 0;
    z_valid = 0; z_addr = 0; z_wdata = 0; z_pready = 0; z_prdata = 0; z_pexcept = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_pvalid", pvalid, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 1);
    chk("rst_pfields", {pwstb, paddr, pwdata}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    chk("rst_except", {a_exc, b_exc}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Contention from reset, then randomized traffic with stalls, timeouts and protocol violations.
    fork
      rand_driver(0, 40);
      rand_driver(1, 40);
    join
    repeat (3) @(posedge clk);

    // Single read answered on the second BUSY cycle.
    fix_en = 1; fix_lat = 2; fix_data = 32'hDEADBEEF; fix_exc = 0;
    do_req(0, 4'h0, 32'h0000_1000, 32'h0, 0);
    chk("read_rdata", a_rdata, 32'hDEADBEEF);
    chk("read_except", a_exc, 0);

    // Write from B with an error response.
    fix_lat = 1; fix_data = 32'h0; fix_exc = 1;
    do_req(1, 4'hF, 32'h0000_2000, 32'h1234_5678, 0);
    chk("write_except", b_exc, 1);
    chk("write_pwdata", pwdata, 32'h1234_5678);

    // Downstream never answers: abort after 8 cycles.
    fix_lat = 20; fix_data = 32'hFFFF_FFFF; fix_exc = 0;
    do_req(0, 4'h0, 32'h0000_1004, 32'h0, 0);
    chk("timeout_rdata", a_rdata, 32'h0);
    chk("timeout_except", a_exc, 1);

    // PREADY on the last allowed cycle wins over the abort.
    fix_lat = 8; fix_data = 32'hCAFE_F00D; fix_exc = 0;
    do_req(0, 4'h0, 32'h0000_1008, 32'h0, 0);
    chk("edge_rdata", a_rdata, 32'hCAFE_F00D);
    chk("edge_except", a_exc, 0);

    // Reset in the middle of a BUSY transaction.
    fix_lat = 20;
    @(posedge clk); #1 wstb[0] = 4'h0; addr[0] = 32'h0000_3000; valid[0] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!pvalid && k < 20);
    chk("rst_mid_pvalid_before", pvalid, 1);
    @(posedge clk); #2 rst_n = 1'b0; valid[0] = 1'b0;
    #1;
    chk("rst_mid_pvalid", pvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_grant", grant, 1);
    chk("rst_mid_ready", {a_ready, b_ready}, 0);
    chk("rst_mid_paddr", paddr, 0);
    chk("rst_mid_rdata", {a_rdata, a_exc}, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    fix_lat = 3; fix_data = 32'h0BAD_F00D; fix_exc = 0;
    do_req(0, 4'h0, 32'h0000_3004, 32'h0, 0);
    chk("post_rst_rdata", a_rdata, 32'h0BAD_F00D);
    fix_en = 0;

    // TIMEOUT=0 instance: a 5000-cycle stall must not abort.
    @(posedge clk); #1 z_addr = 32'h0000_2000; z_wdata = 32'h0000_0077; z_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!z_pvalid && k < 20);
    chk("z_pvalid_start", z_pvalid, 1);
    chk("z_pfields", {z_pwstb, z_paddr, z_pwdata}, {4'h0, 32'h0000_2000, 32'h0000_0077});
    k = 0;
    repeat (4999) begin
      @(negedge clk);
      if (!z_pvalid || z_a_ready || z_b_ready) k++;
    end
    chk("z_no_abort", k, 0);
    z_pready = 1'b1; z_prdata = 32'h5A5A_1234; z_pexcept = 1'b0;
    @(negedge clk);
    z_pready = 1'b0;
    chk("z_pvalid_end", z_pvalid, 0);
    chk("z_ready", {z_a_ready, z_b_ready}, 2'b10);
    chk("z_rdata", z_a_rdata, 32'h5A5A_1234);
    chk("z_except", z_a_exc, 0);
    chk("z_busy", z_busy, 1);
    @(posedge clk); #1 z_valid = 1'b0;
    @(negedge clk);
    chk("z_ready_once", z_a_ready, 0);
    chk("z_b_untouched", {z_grant, z_b_rdata, z_b_exc}, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_mem_arb.md
DEBUG_MEM_ARB -- requirements
Module: debug_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023; downstream cycles without PREADY before abort; 0 disables the timeout.
REQ-002 SHALL have ports: CLK  in  1  system clock, rising edge; the only clock.
REQ-003 SHALL have ports: RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: A_VALID in 1, A_WSTB in 4, A_ADDR in 32, A_WDATA in 32; requester A (abstract-command memory access). A_WSTB=0 means read.
REQ-005 SHALL have ports: A_READY out 1, A_RDATA out 32, A_EXCEPT out 1; completion to requester A.
REQ-006 SHALL have ports: B_VALID, B_WSTB, B_ADDR, B_WDATA (in) and B_READY, B_RDATA, B_EXCEPT (out); requester B (system-bus access), with the same widths as A.
REQ-007 SHALL have ports: PVALID out 1, PWSTB out 4, PADDR out 32, PWDATA out 32, PREADY in 1, PRDATA in 32, PEXCEPT in 1; shared downstream memory port.
REQ-008 SHALL have ports: BUSY out 1 (transaction in flight) and GRANT out 1 (0=A, 1=B, last/current owner).

Function
REQ-009 Protocol on all ports SHALL be: VALID held high with stable fields until READY; READY is a 1-cycle pulse; the requester drops VALID the cycle after READY.
REQ-010 FSM SHALL have states IDLE, BUSY, DONE.
REQ-011 IDLE: if A_VALID or B_VALID is sampled high, the FSM SHALL grant one requester and latch its WSTB/ADDR/WDATA into PWSTB/PADDR/PWDATA; next state BUSY.
REQ-012 Arbitration SHALL be round-robin: with only one VALID, grant it; with both, grant the requester not equal to GRANT.
REQ-013 GRANT SHALL update only on a grant in IDLE.
REQ-014 BUSY: PVALID SHALL be 1, and fields SHALL stay stable whatever the requester inputs do.
REQ-015 BUSY with PREADY=1: the FSM SHALL latch PRDATA into the granted requester's RDATA and PEXCEPT into its EXCEPT, drive PVALID=0 next cycle, and go to DONE.
REQ-016 DONE: the granted requester's READY SHALL be 1 for exactly one cycle, the other requester's READY SHALL stay 0, and next state SHALL be IDLE.
REQ-017 Latency SHALL be: VALID sampled at edge n gives PVALID high after edge n; PREADY sampled at edge k gives READY high after edge k; READY occurs no sooner than 2 cycles after VALID.
REQ-018 Timeout: a cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without PREADY. When it equals TIMEOUT-1 and PREADY=0, the FSM SHALL drop PVALID, set RDATA=0 and EXCEPT=1 for the owner, and go to DONE. The counter SHALL be $clog2(TIMEOUT+1) bits and never wrap.
REQ-019 PREADY and timeout in the same cycle: PREADY SHALL win and PRDATA/PEXCEPT are returned.
REQ-020 The requester being served SHALL not be able to cause a new grant until IDLE is re-entered; back-to-back requests from one requester cost 3 cycles each minimum.
REQ-021 RDATA/EXCEPT SHALL hold their last value until the next completion to that requester.
REQ-022 BUSY output SHALL be 1 in the BUSY and DONE states.
REQ-023 PREADY outside BUSY SHALL be ignored.
REQ-024 A_VALID deasserting during BUSY (protocol violation) SHALL not abort the transaction, and completion still pulses A_READY.

Reset
REQ-025 RST_N low SHALL immediately force: state IDLE, PVALID=0, A_READY=B_READY=0, BUSY=0, GRANT=1 (so A wins the first contention), counter=0, and PWSTB/PADDR/PWDATA/A_RDATA/B_RDATA=0, A_EXCEPT=B_EXCEPT=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no READY pulse, and PVALID SHALL drop asynchronously.
REQ-027 Release SHALL take effect synchronously; first grant possible at the first edge after RST_N is high.

Verification
REQ-028 Single read: A_VALID, A_WSTB=0, A_ADDR=0x1000; PREADY at 2nd BUSY cycle with PRDATA=0xDEADBEEF -> PADDR=0x1000, one A_READY pulse, A_RDATA=0xDEADBEEF, A_EXCEPT=0, B_READY never high.
REQ-029 Contention: A and B VALID together from reset, continuously re-requesting -> grant order A,B,A,B; GRANT toggles; no overlap of PVALID transactions.
REQ-030 Write: B_WSTB=0xF, B_WDATA=0x12345678, PREADY with PEXCEPT=1 -> PWDATA=0x12345678, B_READY pulse, B_EXCEPT=1.
REQ-031 Timeout: TIMEOUT=8, PREADY held 0 -> PVALID high exactly 8 cycles, then A_READY pulse with A_RDATA=0, A_EXCEPT=1; the simultaneous PREADY-at-8th-cycle case returns PRDATA.
REQ-032 Reset during BUSY: RST_N low for 1 cycle -> PVALID low at once, no READY pulse, GRANT=1, then a new A request is served normally.
REQ-033 TIMEOUT=0: PREADY delayed 5000 cycles -> no abort, normal completion.
